// File: rtl/abs_sign_accum.sv
// Per-packet L1 norm and signum histogram of a signed sample stream (optional max |x| via ABS_SIGN_ACCUM_MAX_EN).
// Latency: totals appear 1 cycle after the last beat is accepted; one bubble cycle after the result is taken.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
module abs_sign_accum #(
  parameter int W     = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_pos,
  output logic [CNT_W-1:0] out_neg,
  output logic [CNT_W-1:0] out_zero,
  output logic             out_ovf
`ifdef ABS_SIGN_ACCUM_MAX_EN
  ,
  output logic [W-1:0]     out_max
`endif
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] neg;
    logic [CNT_W-1:0] zero;
    logic             ovf;
  } stats_t;

  logic [0:0]     state;
  stats_t         acc_q;
  stats_t         acc_nxt;
  stats_t         res_q;
  logic [W-1:0]   mag;
  logic [ACC_W:0] mag_ext;
  logic [ACC_W:0] sum_wide;
  logic           is_neg;
  logic           is_zero;
  logic           is_pos;
  logic           pos_sat;
  logic           neg_sat;
  logic           zero_sat;
  logic           sum_sat;
  logic           beat_acc;

  // Returns {saturated, next_value}; the flag is set only when an increment is lost.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (&c))
      return {1'b1, c};
    else if (en)
      return {1'b0, c + CNT_W'(1)};
    else
      return {1'b0, c};
  endfunction

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign beat_acc  = in_valid && in_ready;

  // W-bit unsigned magnitude keeps the most negative sample exact.
  assign is_neg  = in_data[W-1];
  assign is_zero = (in_data == '0);
  assign is_pos  = !is_neg && !is_zero;
  assign mag     = is_neg ? (~in_data + W'(1)) : in_data;

  always_comb begin
    mag_ext         = '0;
    mag_ext[W-1:0]  = mag;
    sum_wide        = {1'b0, acc_q.sum} + mag_ext;
    acc_nxt         = acc_q;
    {pos_sat,  acc_nxt.pos}  = sat_inc(acc_q.pos,  is_pos);
    {neg_sat,  acc_nxt.neg}  = sat_inc(acc_q.neg,  is_neg);
    {zero_sat, acc_nxt.zero} = sat_inc(acc_q.zero, is_zero);
    sum_sat         = sum_wide[ACC_W];
    acc_nxt.sum     = sum_sat ? '1 : sum_wide[ACC_W-1:0];
    acc_nxt.ovf     = acc_q.ovf | pos_sat | neg_sat | zero_sat | sum_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      acc_q <= '0;
      res_q <= '0;
    end else if (state == ST_ACCUM) begin
      if (beat_acc) begin
        if (in_last) begin
          res_q <= acc_nxt;
          acc_q <= '0;
          state <= ST_HOLD;
        end else begin
          acc_q <= acc_nxt;
        end
      end
    end else begin
      if (out_ready)
        state <= ST_ACCUM;
    end
  end

  assign out_sum  = res_q.sum;
  assign out_pos  = res_q.pos;
  assign out_neg  = res_q.neg;
  assign out_zero = res_q.zero;
  assign out_ovf  = res_q.ovf;

`ifdef ABS_SIGN_ACCUM_MAX_EN
  logic [W-1:0] max_q;
  logic [W-1:0] max_nxt;
  logic [W-1:0] max_res_q;

  assign max_nxt = (mag > max_q) ? mag : max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      max_res_q <= '0;
    end else if (beat_acc) begin
      if (in_last) begin
        max_res_q <= max_nxt;
        max_q     <= '0;
      end else begin
        max_q <= max_nxt;
      end
    end
  end

  assign out_max = max_res_q;
`endif

endmodule

// File: tb/tb_abs_sign_accum.sv
// Bench for abs_sign_accum: directed W=8/CNT_W=4 scenarios, then random W=16 packets against a reference model.
// Latency: checks results 1 cycle after the last beat; sampling on the falling edge.
// Backpressure: exercises held results with out_ready low and random out_ready.
module tb_abs_sign_accum;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_ird, a_last, a_ov, a_oready, a_ovf;
  logic [7:0]  a_data;
  logic [11:0] a_sum;
  logic [3:0]  a_pos, a_neg, a_zero;

  logic        b_valid, b_ird, b_last, b_ov, b_oready, b_ovf;
  logic [15:0] b_data;
  logic [31:0] b_sum;
  logic [15:0] b_pos, b_neg, b_zero;

`ifdef ABS_SIGN_ACCUM_MAX_EN
  logic [7:0]  a_max;
  logic [15:0] b_max;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint sum;
    int     pos;
    int     neg;
    int     zero;
    int     ovf;
    int     mx;
  } exp_t;
  exp_t exp_q[$];

  abs_sign_accum #(.W(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_ird), .in_data(a_data), .in_last(a_last),
    .out_valid(a_ov), .out_ready(a_oready), .out_sum(a_sum),
    .out_pos(a_pos), .out_neg(a_neg), .out_zero(a_zero), .out_ovf(a_ovf)
`ifdef ABS_SIGN_ACCUM_MAX_EN
    , .out_max(a_max)
`endif
  );

  abs_sign_accum #(.W(16), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ird), .in_data(b_data), .in_last(b_last),
    .out_valid(b_ov), .out_ready(b_oready), .out_sum(b_sum),
    .out_pos(b_pos), .out_neg(b_neg), .out_zero(b_zero), .out_ovf(b_ovf)
`ifdef ABS_SIGN_ACCUM_MAX_EN
    , .out_max(b_max)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_a(input string tag, input int sum, input int pos, input int neg,
                       input int zero, input int ovf);
    check({tag, ".valid"}, 64'(a_ov), 64'd1);
    check({tag, ".sum"},   64'(a_sum), 64'(sum));
    check({tag, ".pos"},   64'(a_pos), 64'(pos));
    check({tag, ".neg"},   64'(a_neg), 64'(neg));
    check({tag, ".zero"},  64'(a_zero), 64'(zero));
    check({tag, ".ovf"},   64'(a_ovf), 64'(ovf));
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_a(input logic [7:0] d, input logic last);
    int k;
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_ird) break;
    end
    if (k == 200) begin
      n_cmp++;
      n_bad++;
      $error("FAIL a_accept: observed no in_ready within %0d cycles expected acceptance", k);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic drain_a();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_oready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_oready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 64'(a_ov), 64'd0);
    check("rst.out_sum",   64'(a_sum), 64'd0);
    check("rst.counts",    64'({a_pos, a_neg, a_zero}), 64'd0);
    check("rst.out_ovf",   64'(a_ovf), 64'd0);
    check("rst.b_valid",   64'(b_ov), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 64'(a_ird), 64'd1);
    @(posedge clk);
    #1;

    // Mixed-sign packet; in_ready low for exactly one cycle.
    send_a(8'd3, 1'b0);
    send_a(8'hFB, 1'b0);
    send_a(8'd0, 1'b0);
    send_a(8'd7, 1'b1);
    @(negedge clk);
    chk_a("mixed", 15, 2, 1, 1, 0);
    check("mixed.in_ready_hold", 64'(a_ird), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mixed.in_ready_back", 64'(a_ird), 64'd1);
    check("mixed.valid_drop", 64'(a_ov), 64'd0);
    @(posedge clk);
    #1;

    // Most negative sample, single beat.
    send_a(8'h80, 1'b1);
    @(negedge clk);
    chk_a("minval", 128, 0, 1, 0, 0);
`ifdef ABS_SIGN_ACCUM_MAX_EN
    check("minval.max", 64'(a_max), 64'd128);
`endif
    drain_a();

    // Counter saturation, then sticky ovf clears for the next packet.
    for (int i = 0; i < 17; i++) send_a(8'd1, (i == 16));
    @(negedge clk);
    chk_a("sat", 17, 15, 0, 0, 1);
`ifdef ABS_SIGN_ACCUM_MAX_EN
    check("sat.max", 64'(a_max), 64'd1);
`endif
    drain_a();
    send_a(8'd2, 1'b1);
    @(negedge clk);
    chk_a("after_sat", 2, 1, 0, 0, 0);
    drain_a();

    // Held result under backpressure; an offered beat must wait.
    a_oready = 1'b0;
    send_a(8'd5, 1'b0);
    send_a(8'hFA, 1'b1);
    @(negedge clk);
    chk_a("bp", 11, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_data = 8'd9; a_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_valid", 64'(a_ov), 64'd1);
      check("bp.hold_ready", 64'(a_ird), 64'd0);
      check("bp.hold_sum",   64'(a_sum), 64'd11);
      check("bp.hold_neg",   64'(a_neg), 64'd1);
    end
    a_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.release_ready", 64'(a_ird), 64'd1);
    check("bp.release_valid", 64'(a_ov), 64'd0);
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
    @(negedge clk);
    chk_a("bp.next", 9, 1, 0, 0, 0);
    drain_a();

    // Reset mid-packet drops the partial totals.
    send_a(8'd4, 1'b0);
    send_a(8'hFC, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst.no_stale", 64'(a_ov), 64'd0);
      @(posedge clk);
      #1;
    end
    send_a(8'd1, 1'b1);
    @(negedge clk);
    chk_a("midrst", 1, 1, 0, 0, 0);
    drain_a();

    // Random W=16 packets with input gaps and random out_ready.
    fork
      begin : producer
        for (int p = 0; p < 1000; p++) begin
          int          len, r, v, k;
          logic [15:0] beats[8];
          exp_t        e;
          len = $urandom_range(1, 8);
          e.sum = 0; e.pos = 0; e.neg = 0; e.zero = 0; e.ovf = 0; e.mx = 0;
          for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            beats[i] = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 :
                       (r == 2) ? 16'h7FFF : 16'($urandom);
            v = int'($signed(beats[i]));
            if (v > 0) e.pos++;
            else if (v < 0) e.neg++;
            else e.zero++;
            if (v < 0) v = -v;
            e.sum += v;
            if (v > e.mx) e.mx = v;
          end
          if (e.sum > 64'hFFFF_FFFF) begin e.sum = 64'hFFFF_FFFF; e.ovf = 1; end
          if (e.pos > 65535 || e.neg > 65535 || e.zero > 65535) e.ovf = 1;
          exp_q.push_back(e);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
              end
            end
            b_valid = 1'b1;
            b_data  = beats[i];
            b_last  = (i == len - 1);
            for (k = 0; k < 500; k++) begin
              @(negedge clk);
              if (b_ird) break;
            end
            if (k == 500) begin
              n_cmp++;
              n_bad++;
              $error("FAIL b_accept: observed no in_ready within %0d cycles expected acceptance", k);
            end
            @(posedge clk);
            #1;
            b_valid = 1'b0;
            b_last  = 1'b0;
          end
        end
      end
      begin : consumer
        int   got;
        exp_t e;
        got = 0;
        for (int c = 0; c < 40000 && got < 1000; c++) begin
          @(posedge clk);
          #1;
          b_oready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (b_ov && b_oready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $error("FAIL rand.spurious: observed result %0d expected none", got);
            end else begin
              e = exp_q.pop_front();
              check("rand.sum",  64'(b_sum),  64'(e.sum));
              check("rand.pos",  64'(b_pos),  64'(e.pos));
              check("rand.neg",  64'(b_neg),  64'(e.neg));
              check("rand.zero", 64'(b_zero), 64'(e.zero));
              check("rand.ovf",  64'(b_ovf),  64'(e.ovf));
`ifdef ABS_SIGN_ACCUM_MAX_EN
              check("rand.max",  64'(b_max),  64'(e.mx));
`endif
              got++;
            end
          end
        end
        check("rand.packets", 64'(got), 64'd1000);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
